cook_sequencer: RTL and testbench

- Microwave front-end sequencer; sits directly upstream of the motor/PWM stage.
- Converts debounced button pulses and the door switch into held cook/defrost run levels (start, defrost_start).
- Owns the countdown timer (seconds) and the end-of-cycle beep window.
- Feeds remaining-time to the display stage.

---
 rtl/cook_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cook_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer.sv
// Microwave front-end sequencer: turns debounced button pulses and the door
// switch into held cook/defrost run levels, owns the seconds countdown and
// the end-of-cycle beep window, and exports the remaining time for display.
module cook_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int MAX_SEC     = 999,
    parameter int ADD_SEC     = 30,
    parameter int DEFROST_SEC = 120,
    parameter int BEEP_SEC    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_add,
    input  logic       btn_defrost,
    input  logic       door_open,
    output logic       start,
    output logic       defrost_start,
    output logic [9:0] remain_sec,
    output logic       beep,
    output logic       paused
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;

    localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BEEP_TC  = BW'(BEEP_SEC - 1);
    localparam logic [9:0]    ADD_V    = 10'(ADD_SEC);
    localparam logic [9:0]    DEF_V    = 10'(DEFROST_SEC);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COOK    = 3'd1;
    localparam logic [2:0] S_DEFROST = 3'd2;
    localparam logic [2:0] S_PAUSE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic M_COOK    = 1'b0;
    localparam logic M_DEFROST = 1'b1;

    // Add ADD_SEC at 11 bits so the carry is visible, then clamp to MAX_SEC.
    function automatic logic [9:0] sat_add(input logic [9:0] a);
        logic [10:0] s;
        s = {1'b0, a} + 11'(ADD_SEC);
        if (s > 11'(MAX_SEC))
            s = 11'(MAX_SEC);
        return s[9:0];
    endfunction

    logic [2:0]    state_q,  state_d;
    logic          mode_q,   mode_d;
    logic [9:0]    remain_q, remain_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [BW-1:0] beep_q,   beep_d;

    logic          wrap;
    logic [PW-1:0] presc_inc;
    logic          any_btn;
    logic          run_req;

    assign wrap      = (presc_q == PRE_TC);
    assign presc_inc = wrap ? '0 : presc_q + 1'b1;
    assign any_btn   = btn_start | btn_stop | btn_add | btn_defrost;
    // A start request only counts with the door closed.
    assign run_req   = btn_start & ~door_open;

    // Next-state, timer and prescaler decisions; one transition per cycle.
    always_comb begin
        logic [9:0] base;
        state_d  = state_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        presc_d  = presc_q;
        beep_d   = beep_q;
        base     = remain_q;

        case (state_q)
            S_IDLE: begin
                if (btn_stop) begin
                    remain_d = '0;
                    mode_d   = M_COOK;
                end else if (run_req) begin
                    presc_d = '0;
                    if (remain_q == '0) begin
                        // Quick start: fixed cook time, always plain cook.
                        remain_d = ADD_V;
                        mode_d   = M_COOK;
                        state_d  = S_COOK;
                    end else begin
                        state_d = (mode_q == M_DEFROST) ? S_DEFROST : S_COOK;
                    end
                end else if (btn_defrost) begin
                    remain_d = DEF_V;
                    mode_d   = M_DEFROST;
                end else if (btn_add) begin
                    remain_d = sat_add(remain_q);
                end
            end

            S_COOK, S_DEFROST: begin
                if (btn_stop || door_open) begin
                    // Prescaler keeps its value so resume finishes the second.
                    state_d = S_PAUSE;
                end else begin
                    presc_d = presc_inc;
                    if (wrap && remain_q != '0)
                        base = remain_q - 1'b1;
                    if (btn_add) begin
                        remain_d = sat_add(base);
                    end else if (wrap && remain_q <= 10'd1) begin
                        remain_d = '0;
                        presc_d  = '0;
                        beep_d   = '0;
                        mode_d   = M_COOK;
                        state_d  = S_DONE;
                    end else begin
                        remain_d = base;
                    end
                end
            end

            S_PAUSE: begin
                if (btn_stop) begin
                    remain_d = '0;
                    mode_d   = M_COOK;
                    state_d  = S_IDLE;
                end else if (run_req) begin
                    state_d = (mode_q == M_DEFROST) ? S_DEFROST : S_COOK;
                end else if (btn_add) begin
                    remain_d = sat_add(remain_q);
                end
            end

            S_DONE: begin
                remain_d = '0;
                mode_d   = M_COOK;
                if (any_btn) begin
                    presc_d = '0;
                    beep_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    presc_d = presc_inc;
                    if (wrap) begin
                        if (beep_q == BEEP_TC) begin
                            beep_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            beep_d = beep_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                mode_d   = M_COOK;
                remain_d = '0;
                presc_d  = '0;
                beep_d   = '0;
            end
        endcase
    end

    // State, timer and prescaler registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_COOK;
            remain_q <= '0;
            presc_q  <= '0;
            beep_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
            presc_q  <= presc_d;
            beep_q   <= beep_d;
        end
    end

    assign start         = (state_q == S_COOK);
    assign defrost_start = (state_q == S_DEFROST);
    assign paused        = (state_q == S_PAUSE);
    assign beep          = (state_q == S_DONE);
    assign remain_sec    = remain_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer at CLK_HZ=10 (one second = 10 clocks).
// Inputs are driven and outputs sampled on the falling edge.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_add = 1'b0;
    logic       btn_defrost = 1'b0;
    logic       door_open = 1'b0;
    logic       start;
    logic       defrost_start;
    logic [9:0] remain_sec;
    logic       beep;
    logic       paused;

    int total = 0;
    int bad   = 0;

    cook_sequencer #(
        .CLK_HZ(10), .MAX_SEC(999), .ADD_SEC(30), .DEFROST_SEC(120), .BEEP_SEC(3)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_add(btn_add),
        .btn_defrost(btn_defrost), .door_open(door_open),
        .start(start), .defrost_start(defrost_start), .remain_sec(remain_sec),
        .beep(beep), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs packed as {start, defrost_start, paused, beep}.
    function automatic int flags();
        return {28'd0, start, defrost_start, paused, beep};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();   btn_start = 1'b1;   tick(1); btn_start = 1'b0;   endtask
    task automatic press_stop();    btn_stop = 1'b1;    tick(1); btn_stop = 1'b0;    endtask
    task automatic press_add();     btn_add = 1'b1;     tick(1); btn_add = 1'b0;     endtask
    task automatic press_defrost(); btn_defrost = 1'b1; tick(1); btn_defrost = 1'b0; endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_flags", flags(), 0);
        chk("rst_remain", int'(remain_sec), 0);
        rst = 1'b1;
        tick(1);

        // Two adds then start: full 60 s cook, beep window, back to idle
        press_add();
        chk("add1", int'(remain_sec), 30);
        press_add();
        chk("add2", int'(remain_sec), 60);
        chk("idle_flags", flags(), 0);
        press_start();
        chk("cook_flags", flags(), 4'b1000);
        chk("cook_remain", int'(remain_sec), 60);
        tick(10);
        chk("cook_dec1", int'(remain_sec), 59);
        tick(589);
        chk("cook_last_flags", flags(), 4'b1000);
        chk("cook_last_remain", int'(remain_sec), 1);
        tick(1);
        chk("done_flags", flags(), 4'b0001);
        chk("done_remain", int'(remain_sec), 0);
        tick(29);
        chk("beep_hold", flags(), 4'b0001);
        tick(1);
        chk("beep_end", flags(), 0);

        // Quick start from zero, then stop twice
        press_start();
        chk("quick_remain", int'(remain_sec), 30);
        chk("quick_flags", flags(), 4'b1000);
        press_stop();
        chk("quick_pause", flags(), 4'b0010);
        chk("quick_pause_rem", int'(remain_sec), 30);
        press_stop();
        chk("quick_idle", flags(), 0);
        chk("quick_idle_rem", int'(remain_sec), 0);

        // A button during the beep window ends it without adding time
        press_start();
        tick(300);
        chk("done2_flags", flags(), 4'b0001);
        press_add();
        chk("done2_exit", flags(), 0);
        chk("done2_rem", int'(remain_sec), 0);

        // Defrost, then asynchronous reset mid-defrost at 77 s
        press_defrost();
        chk("defrost_load", int'(remain_sec), 120);
        chk("defrost_idle", flags(), 0);
        press_start();
        chk("defrost_flags", flags(), 4'b0100);
        tick(10);
        chk("defrost_dec", int'(remain_sec), 119);
        tick(420);
        chk("defrost_77", int'(remain_sec), 77);
        rst = 1'b0;
        #1;
        chk("async_flags", flags(), 0);
        chk("async_remain", int'(remain_sec), 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("post_rst_flags", flags(), 0);
        press_start();
        chk("post_rst_mode", flags(), 4'b1000);
        press_stop();
        press_stop();

        // Door opens mid-cook at 45 s with prescaler at 4
        press_add();
        press_add();
        press_start();
        tick(154);
        chk("door_pre", int'(remain_sec), 45);
        door_open = 1'b1;
        tick(1);
        chk("door_pause", flags(), 4'b0010);
        tick(20);
        chk("door_frozen", int'(remain_sec), 45);
        press_start();
        chk("door_start_ign", flags(), 4'b0010);
        door_open = 1'b0;
        tick(1);
        press_start();
        chk("resume_flags", flags(), 4'b1000);
        tick(5);
        chk("resume_hold", int'(remain_sec), 45);
        tick(1);
        chk("resume_dec", int'(remain_sec), 44);
        press_stop();
        press_stop();

        // Saturation and stop-over-start priority
        repeat (40) press_add();
        chk("sat_idle", int'(remain_sec), 999);
        press_start();
        chk("sat_cook", flags(), 4'b1000);
        btn_stop = 1'b1;
        btn_start = 1'b1;
        tick(1);
        btn_stop = 1'b0;
        btn_start = 1'b0;
        chk("stop_wins", flags(), 4'b0010);
        press_add();
        chk("sat_pause", int'(remain_sec), 999);
        press_stop();
        chk("final_idle", flags(), 0);
        chk("final_remain", int'(remain_sec), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
